// File: rtl/sat_adjust_if.sv
// Pixel/side-data bus for sat_adjust: HSV pixel input with valid,
// delay-matched pass-through data, and adjusted pixel output.
interface sat_adjust_if #(
  parameter int unsigned PIX_W  = 24,
  parameter int unsigned PASS_W = 24
) ();
  logic              pixel_in_valid;
  logic [PIX_W-1:0]  pixel_in;
  logic [PASS_W-1:0] pass_in;
  logic [PIX_W-1:0]  pixel_out;
  logic              pixel_out_valid;
  logic [PASS_W-1:0] pass_thru;

  modport master (
    output pixel_in_valid, pixel_in, pass_in,
    input  pixel_out, pixel_out_valid, pass_thru
  );

  modport slave (
    input  pixel_in_valid, pixel_in, pass_in,
    output pixel_out, pixel_out_valid, pass_thru
  );
endinterface

// File: rtl/sat_adjust.sv
// Saturation adjust stage for the HSV video path: bypass, grayscale, fixed
// gain and frame-synchronous fade, 2-cycle pipeline with matched side data.
module sat_adjust #(
  parameter int unsigned HUE_W     = 9,
  parameter int unsigned SAT_W     = 7,
  parameter int unsigned VAL_W     = 8,
  parameter int unsigned PASS_W    = 24,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [GAIN_W-1:0] gain,
  input  logic              frame_start,
  sat_adjust_if.slave       bus,
  output logic              ramp_busy
);
  localparam int unsigned PIX_W  = HUE_W + SAT_W + VAL_W;
  localparam int unsigned PROD_W = SAT_W + GAIN_W;
  localparam int unsigned SHIFT  = GAIN_W - 2;

  localparam logic [GAIN_W-1:0] UNITY     = GAIN_W'(2 ** SHIFT);
  localparam logic [GAIN_W:0]   UNITY_X   = (GAIN_W + 1)'(2 ** SHIFT);
  localparam logic [GAIN_W:0]   STEP_X    = (GAIN_W + 1)'(RAMP_STEP);
  localparam logic [PROD_W-1:0] SAT_MAX_X = PROD_W'((2 ** SAT_W) - 1);

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_GRAY   = 2'b01;
  localparam logic [1:0] MODE_FIXED  = 2'b10;
  localparam logic [1:0] MODE_FADE   = 2'b11;

  typedef enum logic [1:0] {FULL, DOWN, ZERO, UP} fade_state_e;

  logic              en_q;
  logic [1:0]        active_mode;
  logic [GAIN_W-1:0] active_gain;
  fade_state_e       state, state_d;
  logic [GAIN_W-1:0] cur_gain, cur_gain_d;
  logic              ramp_busy_d;
  logic [GAIN_W:0]   gain_dn, gain_up_sum, gain_up;

  logic [HUE_W-1:0]  s1_hue;
  logic [VAL_W-1:0]  s1_val;
  logic [PASS_W-1:0] s1_pass;
  logic              s1_valid;
  logic [PROD_W-1:0] s1_prod;

  logic [SAT_W-1:0]  sat_in;
  logic [GAIN_W-1:0] g_eff;
  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] res;
  logic [SAT_W-1:0]  sat_adj;

  // Enable register and per-frame settings latch
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      active_mode <= MODE_BYPASS;
      active_gain <= UNITY;
    end else begin
      en_q <= en;
      if (frame_start) begin
        active_mode <= mode;
        active_gain <= gain;
      end
    end
  end

  // Fade FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FULL;
      cur_gain  <= UNITY;
      ramp_busy <= 1'b0;
    end else begin
      state     <= state_d;
      cur_gain  <= cur_gain_d;
      ramp_busy <= ramp_busy_d;
    end
  end

  // Fade FSM next state: a transition into a ramp also takes the first step
  always_comb begin
    state_d     = state;
    cur_gain_d  = cur_gain;
    gain_dn     = ({1'b0, cur_gain} >= STEP_X) ? ({1'b0, cur_gain} - STEP_X) : '0;
    gain_up_sum = {1'b0, cur_gain} + STEP_X;
    gain_up     = (gain_up_sum >= UNITY_X) ? UNITY_X : gain_up_sum;
    if (frame_start && (active_mode == MODE_FADE)) begin
      if (en_q && (state != ZERO)) begin
        cur_gain_d = gain_dn[GAIN_W-1:0];
        state_d    = (gain_dn == '0) ? ZERO : DOWN;
      end else if (!en_q && (state != FULL)) begin
        cur_gain_d = gain_up[GAIN_W-1:0];
        state_d    = (gain_up == UNITY_X) ? FULL : UP;
      end
    end
    ramp_busy_d = (state_d == DOWN) || (state_d == UP);
  end

  // Stage 1: effective gain select and multiply
  always_comb begin
    sat_in = bus.pixel_in[VAL_W +: SAT_W];
    g_eff  = UNITY;
    if (en_q) begin
      case (active_mode)
        MODE_GRAY:  g_eff = '0;
        MODE_FIXED: g_eff = active_gain;
        MODE_FADE:  g_eff = cur_gain;
        default:    g_eff = UNITY;
      endcase
    end
    prod_d = PROD_W'(sat_in) * PROD_W'(g_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hue   <= '0;
      s1_val   <= '0;
      s1_pass  <= '0;
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_hue   <= bus.pixel_in[PIX_W-1 -: HUE_W];
      s1_val   <= bus.pixel_in[VAL_W-1:0];
      s1_pass  <= bus.pass_in;
      s1_valid <= bus.pixel_in_valid;
      s1_prod  <= prod_d;
    end
  end

  // Stage 2: drop fraction bits and clamp to the saturation range
  always_comb begin
    res     = s1_prod >> SHIFT;
    sat_adj = (res > SAT_MAX_X) ? {SAT_W{1'b1}} : res[SAT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pixel_out       <= '0;
      bus.pixel_out_valid <= 1'b0;
      bus.pass_thru       <= '0;
    end else begin
      bus.pixel_out       <= {s1_hue, sat_adj, s1_val};
      bus.pixel_out_valid <= s1_valid;
      bus.pass_thru       <= s1_pass;
    end
  end
endmodule

// File: tb/tb_sat_adjust.sv
// Self-checking bench for sat_adjust: vector table plus fade/latch/reset
// sequences, outputs checked against a latency-tagged scoreboard.
module tb_sat_adjust;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned PASS_W = 24;

  logic       clk = 1'b0;
  logic       rst, en, frame_start, ramp_busy;
  logic [1:0] mode;
  logic [7:0] gain;

  always #5 clk = ~clk;

  sat_adjust_if #(.PIX_W(PIX_W), .PASS_W(PASS_W)) bus ();

  sat_adjust dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .gain(gain),
    .frame_start(frame_start), .bus(bus), .ramp_busy(ramp_busy)
  );

  typedef struct {
    logic [23:0] pix;
    logic [23:0] pass;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    int         gain;
    bit         en;
    int         sat;
    int         exp_sat;
  } vec_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   track  = 1'b1;
  vec_t tbl[13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name, input int act, input int exp);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Output monitor: pop expectation on each valid output, check data and latency
  always @(negedge clk) begin
    exp_t e;
    if (track) begin
      if (bus.pixel_out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          fail_msg("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pixel_out", 64'(bus.pixel_out), 64'(e.pix));
          check("pass_thru", 64'(bus.pass_thru), 64'(e.pass));
          check("latency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        fail_msg("missing_output", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_full(input bit fs, input bit v, input logic [8:0] h, input int s,
                            input logic [7:0] vl, input logic [23:0] p, input int es);
    exp_t e;
    frame_start        = fs;
    bus.pixel_in_valid = v;
    bus.pixel_in       = {h, 7'(s), vl};
    bus.pass_in        = p;
    if (v && track) begin
      e.pix  = {h, 7'(es), vl};
      e.pass = p;
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    tick();
    frame_start        = 1'b0;
    bus.pixel_in_valid = 1'b0;
  endtask

  task automatic cycle(input bit fs, input bit v, input int s, input int es);
    cycle_full(fs, v, 9'($urandom_range(0, 511)), s, 8'($urandom_range(0, 255)),
               24'($urandom), es);
  endtask

  task automatic px(input int s, input int es);
    cycle(1'b0, 1'b1, s, es);
  endtask

  task automatic fs_only();
    cycle(1'b1, 1'b0, 0, 0);
  endtask

  task automatic set_en(input bit v);
    en = v;
    tick();
  endtask

  task automatic check_busy(input string name, input bit exp);
    check(name, 64'(ramp_busy), 64'(exp));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    if (sb.size() > 0) begin
      fail_msg("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  function automatic int model(input logic [1:0] m, input int g, input bit e, input int s);
    int eg, r;
    eg = 64;
    if (e) begin
      case (m)
        2'b01:   eg = 0;
        2'b10:   eg = g;
        default: eg = 64;
      endcase
    end
    r = (s * eg) >> 6;
    if (r > 127) r = 127;
    return r;
  endfunction

  initial begin
    tbl[0]  = '{2'b01,   0, 1'b1, 100,   0};
    tbl[1]  = '{2'b10,  32, 1'b1, 100,  50};
    tbl[2]  = '{2'b10,  96, 1'b1, 100, 127};
    tbl[3]  = '{2'b10,  64, 1'b1, 100, 100};
    tbl[4]  = '{2'b10,  64, 1'b1, 127, 127};
    tbl[5]  = '{2'b10, 255, 1'b1, 127, 127};
    tbl[6]  = '{2'b10,   1, 1'b1, 127,   1};
    tbl[7]  = '{2'b10,  32, 1'b1,   1,   0};
    tbl[8]  = '{2'b10,   0, 1'b1,  77,   0};
    tbl[9]  = '{2'b00,   0, 1'b1, 127, 127};
    tbl[10] = '{2'b01,   0, 1'b0, 100, 100};
    tbl[11] = '{2'b10,  32, 1'b0, 100, 100};
    tbl[12] = '{2'b00,  99, 1'b1,   0,   0};

    rst = 1'b1; en = 1'b0; mode = 2'b00; gain = 8'd0; frame_start = 1'b0;
    bus.pixel_in_valid = 1'b0; bus.pixel_in = '0; bus.pass_in = '0;
    tick();
    tick();
    check("rst_valid", 64'(bus.pixel_out_valid), 64'(0));
    check("rst_pixel", 64'(bus.pixel_out), 64'(0));
    check("rst_pass", 64'(bus.pass_thru), 64'(0));
    check_busy("rst_busy", 1'b0);
    rst = 1'b0;

    // Bypass with the reference pixel and side data
    set_en(1'b1);
    mode = 2'b00;
    fs_only();
    cycle_full(1'b0, 1'b1, 9'd200, 100, 8'd50, 24'hABCDEF, 100);
    drain();

    // Vector table: latch settings each frame, then one fixed and one random pixel
    for (int i = 0; i < 13; i++) begin
      int rs;
      mode = tbl[i].mode;
      gain = 8'(tbl[i].gain);
      set_en(tbl[i].en);
      fs_only();
      px(tbl[i].sat, tbl[i].exp_sat);
      rs = $urandom_range(0, 127);
      px(rs, model(tbl[i].mode, tbl[i].gain, tbl[i].en, rs));
    end
    drain();

    // Grayscale, then en falls: one more gray pixel before bypass takes over
    mode = 2'b01;
    set_en(1'b1);
    fs_only();
    px(100, 0);
    en = 1'b0;
    px(100, 0);
    px(100, 100);
    drain();

    // Settings latch: mid-frame change ignored, frame_start pixel uses old mode
    set_en(1'b1);
    mode = 2'b00;
    fs_only();
    px(100, 100);
    mode = 2'b01;
    px(100, 100);
    cycle(1'b1, 1'b1, 100, 100);
    px(100, 0);
    drain();

    // Fade down to zero
    mode = 2'b11;
    fs_only();
    check_busy("fade_latch_busy", 1'b0);
    px(100, 100);
    fs_only(); check_busy("fade48_busy", 1'b1); px(100, 75);
    fs_only(); px(100, 50);
    fs_only(); px(100, 25);
    fs_only(); check_busy("fade0_busy", 1'b0); px(100, 0);
    fs_only(); check_busy("zero_hold_busy", 1'b0); px(100, 0);
    // Zero -> up, then reverse back down
    set_en(1'b0);
    fs_only(); check_busy("up16_busy", 1'b1); px(100, 100);
    set_en(1'b1);
    px(100, 25);
    fs_only(); check_busy("rev_zero_busy", 1'b0); px(100, 0);
    set_en(1'b0);
    fs_only(); fs_only(); fs_only();
    check_busy("up48_busy", 1'b1);
    fs_only();
    check_busy("up_full_busy", 1'b0);
    set_en(1'b1);
    px(100, 100);
    drain();

    // Down two steps, en drops: 48, 64, back to full
    fs_only(); px(100, 75);
    fs_only(); px(100, 50);
    set_en(1'b0);
    fs_only(); check_busy("rev_up_busy", 1'b1);
    set_en(1'b1);
    px(100, 75);
    set_en(1'b0);
    fs_only(); check_busy("rev_full_busy", 1'b0);
    set_en(1'b1);
    px(100, 100);
    drain();

    // Leaving fade holds gain and state; re-entering resumes
    fs_only();
    mode = 2'b01;
    fs_only();
    px(100, 0);
    fs_only(); check_busy("hold_busy", 1'b1);
    mode = 2'b11;
    fs_only();
    px(100, 50);
    check_busy("resume_busy", 1'b1);
    drain();

    // Reset mid-stream with a ramp in progress and grayscale active
    mode = 2'b01;
    fs_only();
    px(100, 0);
    drain();
    track = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      rst = (i == 2);
      cycle(1'b0, 1'b1, 100, 0);
      if (i == 2) begin
        check("mid_rst_valid", 64'(bus.pixel_out_valid), 64'(0));
        check("mid_rst_pixel", 64'(bus.pixel_out), 64'(0));
        check("mid_rst_pass", 64'(bus.pass_thru), 64'(0));
        check_busy("mid_rst_busy", 1'b0);
      end
    end
    rst = 1'b0;
    repeat (3) tick();
    track = 1'b1;
    set_en(1'b1);
    px(100, 100);
    mode = 2'b11;
    fs_only();
    px(100, 100);
    fs_only();
    check_busy("post_rst_busy", 1'b1);
    px(100, 75);
    drain();

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
